// File: rtl/dfr_cfg_pkg.sv
// rtl/dfr_cfg_pkg.sv - shared constants and FSM state types for the DFR config register file
package dfr_cfg_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int CTRL_IDX   = 0;
   localparam int STATUS_IDX = 1;

   // Any byte address with a nonzero bit at or above this position is in the memory window
   localparam int MEM_WIN_SHIFT = 24;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_COMMIT = 2'd1,
      WR_RESP   = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_MEM  = 2'd1,
      RD_RESP = 2'd2
   } rd_state_t;

endpackage

// File: rtl/axi_lite_mem_arb.sv
// rtl/axi_lite_mem_arb.sv - memory port arbiter (write wins) and read-latency counter
module axi_lite_mem_arb #(
   parameter int WW         = 28,
   parameter int MEM_RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_req,
   input  logic [WW-1:0] wr_addr,
   input  logic          rd_req,
   input  logic [WW-1:0] rd_addr,
   output logic          mem_wen,
   output logic          mem_ren,
   output logic [WW+1:0] mem_addr,
   output logic          rd_done
);

   logic       waiting;
   logic [2:0] lat_cnt;

   // A write owns the port for its single commit cycle; a pending read simply retries next cycle
   assign mem_wen  = wr_req;
   assign mem_ren  = rd_req && !waiting && !wr_req;
   assign mem_addr = wr_req  ? {2'b00, wr_addr} :
                     mem_ren ? {2'b00, rd_addr} : '0;
   assign rd_done  = waiting && (lat_cnt == 3'(MEM_RD_LAT));

   // Count cycles from the issued read strobe until the memory data is valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waiting <= 1'b0;
         lat_cnt <= '0;
      end else if (mem_ren) begin
         waiting <= 1'b1;
         lat_cnt <= 3'd1;
      end else if (rd_done) begin
         waiting <= 1'b0;
         lat_cnt <= '0;
      end else if (waiting) begin
         lat_cnt <= lat_cnt + 3'd1;
      end
   end

endmodule

// File: rtl/axi_lite_cfg_regfile.sv
// rtl/axi_lite_cfg_regfile.sv - AXI4-Lite config register file and memory-window bridge; optional CFG_SHADOW_EN
module axi_lite_cfg_regfile
   import dfr_cfg_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 30,
   parameter int NUM_REGS           = 16,
   parameter int MEM_RD_LAT         = 1
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic                            busy,
   input  logic [31:0]                     status_in,
   output logic [NUM_REGS*32-1:0]          cfg_out,
   output logic [NUM_REGS-1:0]             cfg_wr_pulse,
   output logic                            start_pulse,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]   mem_addr,
   output logic                            mem_wen,
   output logic                            mem_ren,
   output logic [31:0]                     mem_wdata,
   output logic [3:0]                      mem_wstrb,
   input  logic [31:0]                     mem_rdata
);

   localparam int WW      = C_S_AXI_ADDR_WIDTH - 2;
   localparam int IW      = $clog2(NUM_REGS);
   localparam int WIN_LSB = MEM_WIN_SHIFT - 2;

   function automatic logic in_mem(input logic [WW-1:0] w);
      return |w[WW-1:WIN_LSB];
   endfunction

   function automatic logic in_reg(input logic [WW-1:0] w);
      return !in_mem(w) && (w < WW'(NUM_REGS));
   endfunction

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;

   logic          live, aw_got, w_got;
   logic [WW-1:0] aw_word, ar_word;
   logic [31:0]   w_data, r_data, wr_val, ar_val;
   logic [3:0]    w_strb;
   logic [1:0]    b_resp, r_resp;
   logic [IW-1:0] aw_idx, ar_idx;
   logic [31:0]   regs [NUM_REGS];
   logic          aw_hs, w_hs, ar_hs, commit, reg_wr, mem_wr_req, wr_err, rd_done;
   logic          unused_addr_lsbs;

   assign unused_addr_lsbs = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign aw_idx        = aw_word[IW-1:0];
   assign S_AXI_AWREADY = live && (wr_state == WR_IDLE) && !aw_got;
   assign S_AXI_WREADY  = live && (wr_state == WR_IDLE) && !w_got;
   assign S_AXI_ARREADY = live && (rd_state == RD_IDLE);
   assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

   assign commit      = (wr_state == WR_COMMIT);
   assign wr_err      = in_mem(aw_word) ? busy : !in_reg(aw_word);
   assign mem_wr_req  = commit && in_mem(aw_word) && !busy;
   assign reg_wr      = commit && in_reg(aw_word) && (aw_idx != IW'(STATUS_IDX));
   assign start_pulse = reg_wr && (aw_idx == IW'(CTRL_IDX)) && w_strb[0] && w_data[0];
   assign mem_wdata   = mem_wen ? w_data : '0;
   assign mem_wstrb   = mem_wen ? w_strb : '0;

   assign S_AXI_BVALID = (wr_state == WR_RESP);
   assign S_AXI_BRESP  = b_resp;
   assign S_AXI_RVALID = (rd_state == RD_RESP);
   assign S_AXI_RDATA  = r_data;
   assign S_AXI_RRESP  = r_resp;

   // Write FSM next state: leave idle once both channels are held or arriving
   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         WR_IDLE:   if ((aw_got || aw_hs) && (w_got || w_hs)) wr_next = WR_COMMIT;
         WR_COMMIT: wr_next = WR_RESP;
         WR_RESP:   if (S_AXI_BREADY) wr_next = WR_IDLE;
         default:   wr_next = WR_IDLE;
      endcase
   end

   // Read FSM next state: register reads answer directly, window reads go through memory
   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE: if (ar_hs) rd_next = in_mem(S_AXI_ARADDR[WW+1:2]) ? RD_MEM : RD_RESP;
         RD_MEM:  if (rd_done) rd_next = RD_RESP;
         RD_RESP: if (S_AXI_RREADY) rd_next = RD_IDLE;
         default: rd_next = RD_IDLE;
      endcase
   end

   // State registers and the post-reset enable that keeps readies low during reset
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
         live     <= 1'b0;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
         live     <= 1'b1;
      end
   end

   // Latch each write channel independently and capture the response at commit
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
         aw_word <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         b_resp  <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_got  <= 1'b1;
            aw_word <= S_AXI_AWADDR[WW+1:2];
         end
         if (w_hs) begin
            w_got  <= 1'b1;
            w_data <= S_AXI_WDATA[31:0];
            w_strb <= S_AXI_WSTRB[3:0];
         end
         if (commit) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            b_resp <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   // Byte-merge the write into the current value; ctrl low bits are never stored
   always_comb begin
      wr_val = regs[aw_idx];
      for (int b = 0; b < 4; b++) begin
         if (w_strb[b]) wr_val[8*b +: 8] = w_data[8*b +: 8];
      end
      if (aw_idx == IW'(CTRL_IDX)) wr_val[1:0] = 2'b00;
   end

   // Register array update on a committed register write
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (reg_wr) begin
         regs[aw_idx] <= wr_val;
      end
   end

   // One pulse per slot on a committed register write
   always_comb begin
      cfg_wr_pulse = '0;
      if (reg_wr) cfg_wr_pulse[aw_idx] = 1'b1;
   end

`ifdef CFG_SHADOW_EN
   logic [31:0] pub [NUM_REGS];

   // Publish all shadow slots together when the core is started
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < NUM_REGS; i++) pub[i] <= '0;
      end else if (start_pulse) begin
         for (int i = 2; i < NUM_REGS; i++) pub[i] <= regs[i];
      end
   end

   // Flatten ctrl plus the published copies; status slot carries no stored value
   always_comb begin
      cfg_out = '0;
      cfg_out[CTRL_IDX*32 +: 32] = regs[CTRL_IDX];
      for (int i = 2; i < NUM_REGS; i++) cfg_out[i*32 +: 32] = pub[i];
   end
`else
   // Flatten the live registers; status slot carries no stored value
   always_comb begin
      cfg_out = '0;
      cfg_out[CTRL_IDX*32 +: 32] = regs[CTRL_IDX];
      for (int i = 2; i < NUM_REGS; i++) cfg_out[i*32 +: 32] = regs[i];
   end
`endif

   // Read value decoded straight from the AR bus so it is sampled before any same-edge write
   always_comb begin
      ar_idx = S_AXI_ARADDR[IW+1:2];
      ar_val = regs[ar_idx];
      if (ar_idx == IW'(CTRL_IDX))        ar_val = {regs[CTRL_IDX][31:2], busy, 1'b0};
      else if (ar_idx == IW'(STATUS_IDX)) ar_val = status_in;
      if (!in_reg(S_AXI_ARADDR[WW+1:2])) ar_val = '0;
   end

   // Read address/data/response capture for both register and memory reads
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         ar_word <= '0;
         r_data  <= '0;
         r_resp  <= RESP_OKAY;
      end else if (ar_hs) begin
         ar_word <= S_AXI_ARADDR[WW+1:2];
         r_data  <= ar_val;
         r_resp  <= (in_reg(S_AXI_ARADDR[WW+1:2]) || in_mem(S_AXI_ARADDR[WW+1:2])) ?
                    RESP_OKAY : RESP_SLVERR;
      end else if (rd_done) begin
         r_data <= mem_rdata;
         r_resp <= RESP_OKAY;
      end
   end

   axi_lite_mem_arb #(
      .WW         (WW),
      .MEM_RD_LAT (MEM_RD_LAT)
   ) u_mem_arb (
      .clk      (S_AXI_ACLK),
      .rst_n    (S_AXI_ARESETN),
      .wr_req   (mem_wr_req),
      .wr_addr  (aw_word),
      .rd_req   (rd_state == RD_MEM),
      .rd_addr  (ar_word),
      .mem_wen  (mem_wen),
      .mem_ren  (mem_ren),
      .mem_addr (mem_addr),
      .rd_done  (rd_done)
   );

endmodule

// File: tb/tb_axi_lite_cfg_regfile.sv
// tb/tb_axi_lite_cfg_regfile.sv - directed self-checking bench for axi_lite_cfg_regfile
module tb_axi_lite_cfg_regfile;

   localparam int NR  = 16;
   localparam int LAT = 2;
`ifdef CFG_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn;
   logic [29:0]   awaddr, araddr;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
   logic [1:0]    BRESP, RRESP;
   logic [31:0]   RDATA;
   logic          busy;
   logic [31:0]   status_in, mem_rdata, mem_wdata;
   logic [NR*32-1:0] cfg_out;
   logic [NR-1:0] cfg_wr_pulse;
   logic          start_pulse, mem_wen, mem_ren;
   logic [29:0]   mem_addr;
   logic [3:0]    mem_wstrb;

   int checks = 0;
   int errors = 0;
   int wr_cnt [NR];
   int n_start = 0, n_wen = 0, n_both = 0;
   logic [29:0] last_maddr = '0;
   logic [31:0] last_mwdata = '0;

   axi_lite_cfg_regfile #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (30),
      .NUM_REGS           (NR),
      .MEM_RD_LAT         (LAT)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rstn),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (AWREADY),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (WREADY),
      .S_AXI_BRESP   (BRESP),
      .S_AXI_BVALID  (BVALID),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (ARREADY),
      .S_AXI_RDATA   (RDATA),
      .S_AXI_RRESP   (RRESP),
      .S_AXI_RVALID  (RVALID),
      .S_AXI_RREADY  (rready),
      .busy          (busy),
      .status_in     (status_in),
      .cfg_out       (cfg_out),
      .cfg_wr_pulse  (cfg_wr_pulse),
      .start_pulse   (start_pulse),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_ren       (mem_ren),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb),
      .mem_rdata     (mem_rdata)
   );

   initial for (int i = 0; i < NR; i++) wr_cnt[i] = 0;

   always @(negedge clk) begin
      for (int i = 0; i < NR; i++) if (cfg_wr_pulse[i] === 1'b1) wr_cnt[i]++;
      if (start_pulse === 1'b1) n_start++;
      if (mem_wen === 1'b1) begin
         n_wen++;
         last_maddr  = mem_addr;
         last_mwdata = mem_wdata;
      end
      if (mem_wen === 1'b1 && mem_ren === 1'b1) n_both++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n;
      logic ah, wh, done;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while ((awvalid || wvalid) && n < 40) begin
         ah = awvalid && AWREADY;
         wh = wvalid && WREADY;
         @(negedge clk); n++;
         if (ah) awvalid = 1'b0;
         if (wh) wvalid = 1'b0;
      end
      check("aw_w_handshake", {31'b0, awvalid | wvalid}, 32'd0);
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1; n = 0; done = 1'b0; resp = 2'bxx;
      while (!done && n < 40) begin
         if (BVALID) begin done = 1'b1; resp = BRESP; end
         @(negedge clk); n++;
      end
      bready = 1'b0;
      check("b_handshake", {31'b0, done}, 32'd1);
   endtask

   task automatic axi_read(input logic [29:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      logic done;
      araddr = a; arvalid = 1'b1; n = 0; done = 1'b0;
      while (!done && n < 40) begin
         done = ARREADY;
         @(negedge clk); n++;
      end
      arvalid = 1'b0;
      check("ar_handshake", {31'b0, done}, 32'd1);
      rready = 1'b1; n = 0; done = 1'b0; d = 'x; resp = 2'bxx;
      while (!done && n < 40) begin
         if (RVALID) begin done = 1'b1; d = RDATA; resp = RRESP; end
         @(negedge clk); n++;
      end
      rready = 1'b0;
      check("r_handshake", {31'b0, done}, 32'd1);
   endtask

   initial begin
      logic [1:0]  r;
      logic [31:0] d;
      int base;

      rstn = 1'b0; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b0; arvalid = 1'b0; rready = 1'b0; wdata = '0; wstrb = '0;
      busy = 1'b0; status_in = 32'h1234_5678; mem_rdata = '0;
      repeat (3) @(negedge clk);

      check("rst_awready", {31'b0, AWREADY}, 32'd0);
      check("rst_wready", {31'b0, WREADY}, 32'd0);
      check("rst_arready", {31'b0, ARREADY}, 32'd0);
      check("rst_valids", {30'b0, BVALID, RVALID}, 32'd0);
      check("rst_cfg_out_zero", {31'b0, cfg_out == '0}, 32'd1);
      check("rst_strobes", {29'b0, mem_wen, mem_ren, start_pulse}, 32'd0);

      rstn = 1'b1;
      @(negedge clk);
      check("idle_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'h7);

      // partial-strobe register write and readback
      base = wr_cnt[2];
      axi_write(30'h08, 32'hDEAD_BEEF, 4'b0011, r);
      check("strb_bresp", {30'b0, r}, 32'd0);
      check("strb_pulse_count", wr_cnt[2] - base, 32'd1);
      axi_read(30'h08, d, r);
      check("strb_rdata", d, 32'h0000_BEEF);
      check("strb_rresp", {30'b0, r}, 32'd0);
      check("strb_cfg_out2", cfg_out[2*32 +: 32], SHADOW ? 32'h0 : 32'h0000_BEEF);

      // W channel three cycles ahead of AW, then a stalled B handshake
      wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1;
      check("early_wready", {31'b0, WREADY}, 32'd1);
      @(negedge clk);
      wvalid = 1'b0;
      check("early_w_latched", {31'b0, WREADY}, 32'd0);
      repeat (2) @(negedge clk);
      base = wr_cnt[3];
      awaddr = 30'h0C; awvalid = 1'b1;
      check("late_awready", {31'b0, AWREADY}, 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      check("late_commit_pulse", {31'b0, cfg_wr_pulse[3]}, 32'd1);
      check("late_no_bvalid_yet", {31'b0, BVALID}, 32'd0);
      @(negedge clk);
      check("late_bvalid", {31'b0, BVALID}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_bvalid", {31'b0, BVALID}, 32'd1);
         check("stall_bresp", {30'b0, BRESP}, 32'd0);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("stall_b_done", {31'b0, BVALID}, 32'd0);
      check("late_pulse_count", wr_cnt[3] - base, 32'd1);
      axi_read(30'h0C, d, r);
      check("late_rdata", d, 32'h1122_3344);

      // start while busy: ctrl readback shows busy and never bit 0
      busy = 1'b1;
      base = n_start;
      axi_write(30'h00, 32'h1, 4'hF, r);
      check("start_bresp", {30'b0, r}, 32'd0);
      check("start_pulse_count", n_start - base, 32'd1);
      axi_read(30'h00, d, r);
      check("ctrl_rdata_busy", d, 32'h2);

      // memory-window write blocked by busy, then allowed
      base = n_wen;
      axi_write(30'h0100_0010, 32'hA5A5_A5A5, 4'hF, r);
      check("memwr_busy_bresp", {30'b0, r}, 32'h2);
      check("memwr_busy_no_wen", n_wen - base, 32'd0);
      busy = 1'b0;
      axi_write(30'h0100_0010, 32'hA5A5_A5A5, 4'hF, r);
      check("memwr_bresp", {30'b0, r}, 32'd0);
      check("memwr_wen_count", n_wen - base, 32'd1);
      check("memwr_addr", {2'b0, last_maddr}, 32'h0040_0004);
      check("memwr_wdata", last_mwdata, 32'hA5A5_A5A5);

      // unmapped accesses
      axi_read(30'h100, d, r);
      check("unmapped_rresp", {30'b0, r}, 32'h2);
      check("unmapped_rdata", d, 32'h0);
      axi_write(30'h100, 32'hFFFF_FFFF, 4'hF, r);
      check("unmapped_bresp", {30'b0, r}, 32'h2);

      // memory-window read with two-cycle memory latency
      araddr = 30'h0200_0000; arvalid = 1'b1; rready = 1'b1;
      check("memrd_arready", {31'b0, ARREADY}, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      check("memrd_ren", {31'b0, mem_ren}, 32'd1);
      check("memrd_addr", {2'b0, mem_addr}, 32'h0080_0000);
      @(negedge clk);
      check("memrd_ren_once", {31'b0, mem_ren}, 32'd0);
      check("memrd_wait1", {31'b0, RVALID}, 32'd0);
      @(negedge clk);
      mem_rdata = 32'hCAFE_F00D;
      check("memrd_wait2", {31'b0, RVALID}, 32'd0);
      @(negedge clk);
      mem_rdata = 32'h0;
      check("memrd_rvalid", {31'b0, RVALID}, 32'd1);
      check("memrd_rdata", RDATA, 32'hCAFE_F00D);
      check("memrd_rresp", {30'b0, RRESP}, 32'd0);
      @(negedge clk);
      rready = 1'b0;
      check("memrd_done", {31'b0, RVALID}, 32'd0);

      // status is read-only
      axi_read(30'h04, d, r);
      check("status_rdata", d, 32'h1234_5678);
      axi_write(30'h04, 32'hFFFF_FFFF, 4'hF, r);
      check("status_wr_bresp", {30'b0, r}, 32'd0);
      axi_read(30'h04, d, r);
      check("status_unchanged", d, 32'h1234_5678);

      // shadow publishing (or direct tracking) of slot 4
      axi_write(30'h10, 32'h5, 4'hF, r);
      check("slot4_before_start", cfg_out[4*32 +: 32], SHADOW ? 32'h0 : 32'h5);
      axi_write(30'h00, 32'h1, 4'hF, r);
      check("slot4_after_start", cfg_out[4*32 +: 32], 32'h5);
      axi_read(30'h10, d, r);
      check("slot4_rdata", d, 32'h5);

      // reset while the write response is pending
      awaddr = 30'h14; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_resp_bvalid_before", {31'b0, BVALID}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("rst_in_resp_bvalid", {31'b0, BVALID}, 32'd0);
      check("rst_in_resp_cfg_zero", {31'b0, cfg_out == '0}, 32'd1);
      check("rst_in_resp_awready", {31'b0, AWREADY}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      axi_read(30'h08, d, r);
      check("post_rst_reg_cleared", d, 32'h0);

      check("no_wen_ren_overlap", n_both, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
